// File: rtl/product_bcd_pkg.sv
// Shared constants for the product-to-BCD converter and its multiplexed 7-segment display.
// Segment patterns are packed {a,b,c,d,e,f,g}, with segment a in bit 6.
package product_bcd_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam int NUM_DIGITS = 5;
    localparam int BIN_W      = 16;
    localparam int BCD_W      = 4 * NUM_DIGITS;
    localparam int CNT_W      = 5;
    localparam int IDX_W      = 3;

    localparam logic [6:0] SEG_0 = 7'b1111110;
    localparam logic [6:0] SEG_1 = 7'b0110000;
    localparam logic [6:0] SEG_2 = 7'b1101101;
    localparam logic [6:0] SEG_3 = 7'b1111001;
    localparam logic [6:0] SEG_4 = 7'b0110011;
    localparam logic [6:0] SEG_5 = 7'b1011011;
    localparam logic [6:0] SEG_6 = 7'b1011111;
    localparam logic [6:0] SEG_7 = 7'b1110000;
    localparam logic [6:0] SEG_8 = 7'b1111111;
    localparam logic [6:0] SEG_9 = 7'b1111011;

    // Codes 10-15 never occur in a valid BCD digit; they light nothing.
    function automatic logic [6:0] seg_pattern(input logic [3:0] digit);
        case (digit)
            4'd0:    seg_pattern = SEG_0;
            4'd1:    seg_pattern = SEG_1;
            4'd2:    seg_pattern = SEG_2;
            4'd3:    seg_pattern = SEG_3;
            4'd4:    seg_pattern = SEG_4;
            4'd5:    seg_pattern = SEG_5;
            4'd6:    seg_pattern = SEG_6;
            4'd7:    seg_pattern = SEG_7;
            4'd8:    seg_pattern = SEG_8;
            4'd9:    seg_pattern = SEG_9;
            default: seg_pattern = 7'b0000000;
        endcase
    endfunction

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational BCD nibble to active-high 7-segment decoder with a blanking input.
module bcd_to_7seg
    import product_bcd_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       blank,
    output logic [6:0] seg
);

    always_comb begin
        seg = blank ? 7'b0000000 : seg_pattern(digit);
    end

endmodule

// File: rtl/product_bcd_display.sv
// Converts a 16-bit product to five BCD digits by double-dabble on each rising edge of
// done_flag, then scans the registered result onto a multiplexed 7-segment display.
module product_bcd_display
    import product_bcd_pkg::*;
#(
    parameter int SCAN_DIV = 1024,
    parameter int BLANK_LZ = 1
) (
    input  logic        clk,
    input  logic        sclr_n,
    input  logic        done_flag,
    input  logic [15:0] product8_8,
    output logic [19:0] bcd_out,
    output logic        bcd_valid,
    output logic        busy,
    output logic [4:0]  dig_en,
    output logic        seg_a,
    output logic        seg_b,
    output logic        seg_c,
    output logic        seg_d,
    output logic        seg_e,
    output logic        seg_f,
    output logic        seg_g
);

    localparam int SCAN_W = $clog2(SCAN_DIV);

    logic [1:0]        state_q, state_d;
    logic              done_d_q, done_d_d;
    logic [BIN_W-1:0]  bin_q, bin_d;
    logic [BCD_W-1:0]  scratch_q, scratch_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              pending_q, pending_d;
    logic [BIN_W-1:0]  pend_op_q, pend_op_d;
    logic [BCD_W-1:0]  bcd_out_q, bcd_out_d;
    logic              bcd_valid_q, bcd_valid_d;
    logic [SCAN_W-1:0] scan_cnt_q, scan_cnt_d;
    logic [IDX_W-1:0]  dig_idx_q, dig_idx_d;

    logic              trigger;
    logic [BCD_W-1:0]  adjusted;
    logic [3:0]        cur_digit;
    logic              upper_zero;
    logic              blank;
    logic [6:0]        seg;

    assign trigger = done_flag & ~done_d_q;

    // NOTE: every signal assigned here gets a default first, so no path leaves a latch.
    always_comb begin
        state_d     = state_q;
        done_d_d    = done_flag;
        bin_d       = bin_q;
        scratch_d   = scratch_q;
        cnt_d       = cnt_q;
        pending_d   = pending_q;
        pend_op_d   = pend_op_q;
        bcd_out_d   = bcd_out_q;
        bcd_valid_d = 1'b0;
        adjusted    = scratch_q;

        case (state_q)
            ST_IDLE: begin
                if (trigger) begin
                    bin_d     = product8_8;
                    scratch_d = '0;
                    cnt_d     = '0;
                    state_d   = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    if (adjusted[4*i +: 4] >= 4'd5) begin
                        adjusted[4*i +: 4] = adjusted[4*i +: 4] + 4'd3;
                    end
                end
                {scratch_d, bin_d} = {adjusted, bin_q} << 1;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(BIN_W - 1)) begin
                    state_d = ST_DONE;
                end
                if (trigger) begin
                    pending_d = 1'b1;
                    pend_op_d = product8_8;
                end
            end
            ST_DONE: begin
                bcd_out_d   = scratch_q;
                bcd_valid_d = 1'b1;
                // A trigger on this very edge is the newest operand and wins over the queued one.
                if (trigger || pending_q) begin
                    bin_d     = trigger ? product8_8 : pend_op_q;
                    scratch_d = '0;
                    cnt_d     = '0;
                    pending_d = 1'b0;
                    state_d   = ST_SHIFT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        scan_cnt_d = scan_cnt_q + SCAN_W'(1);
        dig_idx_d  = dig_idx_q;
        if (scan_cnt_q == SCAN_W'(SCAN_DIV - 1)) begin
            scan_cnt_d = '0;
            dig_idx_d  = (dig_idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : dig_idx_q + 1'b1;
        end
    end

    // The display only ever looks at the registered result, never the scratch register.
    always_comb begin
        cur_digit  = 4'd0;
        upper_zero = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (dig_idx_q == IDX_W'(i)) begin
                cur_digit = bcd_out_q[4*i +: 4];
            end
            if (IDX_W'(i) >= dig_idx_q && bcd_out_q[4*i +: 4] != 4'd0) begin
                upper_zero = 1'b0;
            end
        end
        blank = (BLANK_LZ != 0) && (dig_idx_q != '0) && upper_zero;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (!sclr_n) begin
            state_q     <= ST_IDLE;
            done_d_q    <= 1'b1;
            bin_q       <= '0;
            scratch_q   <= '0;
            cnt_q       <= '0;
            pending_q   <= 1'b0;
            pend_op_q   <= '0;
            bcd_out_q   <= '0;
            bcd_valid_q <= 1'b0;
            scan_cnt_q  <= '0;
            dig_idx_q   <= '0;
        end else begin
            state_q     <= state_d;
            done_d_q    <= done_d_d;
            bin_q       <= bin_d;
            scratch_q   <= scratch_d;
            cnt_q       <= cnt_d;
            pending_q   <= pending_d;
            pend_op_q   <= pend_op_d;
            bcd_out_q   <= bcd_out_d;
            bcd_valid_q <= bcd_valid_d;
            scan_cnt_q  <= scan_cnt_d;
            dig_idx_q   <= dig_idx_d;
        end
    end

    bcd_to_7seg u_seg_dec (
        .digit (cur_digit),
        .blank (blank),
        .seg   (seg)
    );

    assign bcd_out   = bcd_out_q;
    assign bcd_valid = bcd_valid_q;
    assign busy      = (state_q != ST_IDLE);
    assign dig_en    = 5'b00001 << dig_idx_q;
    assign {seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g} = seg;

endmodule

// File: tb/tb_product_bcd_display.sv
// Self-checking bench: a cycle-level behavioural model built from decimal arithmetic is
// compared against every DUT output each cycle, alongside hand-computed directed checks.
module tb_product_bcd_display;

    localparam int SCAN_DIV = 4;
    localparam int BLANK_LZ = 1;

    logic        clk = 1'b0;
    logic        sclr_n;
    logic        done_flag;
    logic [15:0] product8_8;
    logic [19:0] bcd_out;
    logic        bcd_valid;
    logic        busy;
    logic [4:0]  dig_en;
    logic        seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g;
    logic [6:0]  segs;

    always #5 clk = ~clk;
    assign segs = {seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g};

    product_bcd_display #(.SCAN_DIV(SCAN_DIV), .BLANK_LZ(BLANK_LZ)) dut (
        .clk        (clk),
        .sclr_n     (sclr_n),
        .done_flag  (done_flag),
        .product8_8 (product8_8),
        .bcd_out    (bcd_out),
        .bcd_valid  (bcd_valid),
        .busy       (busy),
        .dig_en     (dig_en),
        .seg_a      (seg_a),
        .seg_b      (seg_b),
        .seg_c      (seg_c),
        .seg_d      (seg_d),
        .seg_e      (seg_e),
        .seg_f      (seg_f),
        .seg_g      (seg_g)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    function automatic int pow10(input int n);
        int r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    function automatic logic [19:0] to_bcd(input int v);
        logic [19:0] r = '0;
        for (int i = 0; i < 5; i++) r[4*i +: 4] = 4'((v / pow10(i)) % 10);
        return r;
    endfunction

    // Segment pattern built straight from the letter list of each numeral.
    function automatic logic [6:0] seg_of(input int d);
        string s;
        logic [6:0] r = '0;
        case (d)
            0: s = "abcdef";  1: s = "bc";     2: s = "abdeg";  3: s = "abcdg";
            4: s = "bcfg";    5: s = "acdfg";  6: s = "acdefg"; 7: s = "abc";
            8: s = "abcdefg"; default: s = "abcdfg";
        endcase
        for (int i = 0; i < s.len(); i++) r[6 - (int'(s[i]) - 97)] = 1'b1;
        return r;
    endfunction

    // Behavioural model: conversions as (operand, finish cycle) plus a one-deep queue.
    int          cyc = 0;
    bit          cmp_en = 1'b0;
    bit          m_prev = 1'b1;
    bit          m_active = 1'b0;
    int          m_end = 0;
    logic [15:0] m_op = '0;
    bit          m_has_pend = 1'b0;
    logic [15:0] m_pend_op = '0;
    int          m_val = 0;
    bit          m_valid = 1'b0;
    int          m_scan = 0;
    int          m_idx = 0;

    always @(posedge clk) begin
        bit trig;
        cyc++;
        if (!sclr_n) begin
            m_prev = 1'b1; m_active = 1'b0; m_has_pend = 1'b0;
            m_val = 0; m_valid = 1'b0; m_scan = 0; m_idx = 0;
            cmp_en = 1'b1;
        end else begin
            trig    = done_flag && !m_prev;
            m_prev  = done_flag;
            m_valid = 1'b0;
            if (trig) begin
                if (!m_active) begin
                    m_active = 1'b1; m_op = product8_8; m_end = cyc + 17;
                end else begin
                    m_has_pend = 1'b1; m_pend_op = product8_8;
                end
            end
            if (m_active && cyc == m_end) begin
                m_val   = int'(m_op);
                m_valid = 1'b1;
                if (m_has_pend) begin
                    m_op = m_pend_op; m_end = cyc + 17; m_has_pend = 1'b0;
                end else begin
                    m_active = 1'b0;
                end
            end
            if (m_scan == SCAN_DIV - 1) begin
                m_scan = 0; m_idx = (m_idx + 1) % 5;
            end else begin
                m_scan++;
            end
        end
    end

    function automatic logic [6:0] model_segs();
        bit lead = (BLANK_LZ != 0) && (m_idx > 0) && (m_val < pow10(m_idx));
        return lead ? 7'b0 : seg_of((m_val / pow10(m_idx)) % 10);
    endfunction

    always @(negedge clk) begin
        if (cmp_en) begin
            check("bcd_out",   32'(bcd_out),   32'(to_bcd(m_val)));
            check("bcd_valid", 32'(bcd_valid), 32'(m_valid));
            check("busy",      32'(busy),      32'(m_active));
            check("dig_en",    32'(dig_en),    32'(5'b00001 << m_idx));
            check("segs",      32'(segs),      32'(model_segs()));
        end
    end

    // Starts a conversion at the next edge and returns cycles-to-valid and busy cycles seen.
    task automatic run_conv(input logic [15:0] op, output int lat, output int busy_cyc);
        product8_8 = op;
        done_flag  = 1'b1;
        @(posedge clk);
        lat = -1;
        busy_cyc = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (k == 0) done_flag = 1'b0;
            if (busy) busy_cyc++;
            if (bcd_valid) begin
                lat = k;
                break;
            end
        end
    endtask

    // Waits (bounded) for a given digit slot and returns its segments.
    task automatic seg_at_slot(input logic [4:0] slot, output logic [6:0] s);
        s = 7'bx;
        for (int k = 0; k < 4 * SCAN_DIV * 5; k++) begin
            @(negedge clk);
            if (dig_en == slot) begin
                s = segs;
                break;
            end
        end
    endtask

    initial begin
        int lat, bc, nv, gap;
        logic [6:0] s;
        sclr_n = 1'b0; done_flag = 1'b1; product8_8 = '0;
        repeat (2) @(negedge clk);
        check("rst_bcd_out", 32'(bcd_out), 32'h0);
        check("rst_busy",    32'(busy),    32'h0);
        check("rst_dig_en",  32'(dig_en),  32'h01);
        check("rst_segs",    32'(segs),    32'h7E);
        sclr_n = 1'b1;
        repeat (3) @(negedge clk);
        check("held_done_no_trigger", 32'(busy), 32'h0);
        done_flag = 1'b0;
        @(negedge clk);

        run_conv(16'hFE01, lat, bc);
        check("fe01_latency", 32'(lat), 32'd17);
        check("fe01_busy_cycles", 32'(bc), 32'd17);
        check("fe01_value", 32'(bcd_out), 32'h65025);
        repeat (3) @(negedge clk);

        run_conv(16'h0000, lat, bc);
        check("zero_value", 32'(bcd_out), 32'h0);
        seg_at_slot(5'b00001, s);
        check("zero_slot0", 32'(s), 32'h7E);
        seg_at_slot(5'b00100, s);
        check("zero_slot2_blank", 32'(s), 32'h0);

        run_conv(16'd9999, lat, bc);
        check("9999_value", 32'(bcd_out), 32'h09999);
        seg_at_slot(5'b01000, s);
        check("9999_slot3", 32'(s), 32'h7B);
        seg_at_slot(5'b10000, s);
        check("9999_slot4_blank", 32'(s), 32'h0);
        repeat (2 * 5 * SCAN_DIV) @(negedge clk);

        run_conv(16'hFFFF, lat, bc);
        check("ffff_value", 32'(bcd_out), 32'h65535);
        repeat (2) @(negedge clk);

        // Back-to-back: second trigger lands mid-conversion.
        product8_8 = 16'h0051; done_flag = 1'b1;
        @(posedge clk);
        nv = 0; gap = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (k == 0) done_flag = 1'b0;
            if (k == 4) begin product8_8 = 16'h1000; done_flag = 1'b1; end
            if (k == 5) done_flag = 1'b0;
            if (!busy && k < 34) gap++;
            if (bcd_valid) begin
                if (nv == 0) begin
                    check("b2b_first_value", 32'(bcd_out), 32'h00081);
                    check("b2b_first_cycle", 32'(k), 32'd17);
                end else begin
                    check("b2b_second_value", 32'(bcd_out), 32'h04096);
                    check("b2b_second_cycle", 32'(k), 32'd34);
                end
                nv++;
            end
        end
        check("b2b_valid_count", 32'(nv), 32'd2);
        check("b2b_busy_gaps", 32'(gap), 32'd0);

        // Reset mid-conversion with done_flag still high.
        product8_8 = 16'h1234; done_flag = 1'b1;
        @(posedge clk);
        repeat (8) @(negedge clk);
        sclr_n = 1'b0;
        @(negedge clk);
        sclr_n = 1'b1;
        nv = 0;
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            if (bcd_valid) nv++;
        end
        check("abort_no_valid", 32'(nv), 32'd0);
        check("abort_bcd_zero", 32'(bcd_out), 32'h0);
        check("abort_no_retrigger", 32'(busy), 32'h0);
        done_flag = 1'b0;
        @(negedge clk);
        run_conv(16'h1234, lat, bc);
        check("retrigger_value", 32'(bcd_out), 32'h04660);
        check("retrigger_latency", 32'(lat), 32'd17);

        // A long done_flag pulse converts once.
        product8_8 = 16'd300; done_flag = 1'b1;
        nv = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bcd_valid) nv++;
        end
        done_flag = 1'b0;
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            if (bcd_valid) nv++;
        end
        check("long_pulse_one_conv", 32'(nv), 32'd1);
        check("long_pulse_value", 32'(bcd_out), 32'h00300);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
